ddr_pi_code_stepper: RTL and testbench

Sequencer that owns one phase-interpolator (PI) channel's code, enable and gear. It walks the PI binary code toward a requested target one LSB at a time, with a programmable dwell between steps, so the PI output never sees a multi-LSB phase jump. It also sequences enable and settle so gear changes happen only while the PI is disabled. The parent packs the outputs into the PI config bus that feeds the b2t decoder and PI macro.

---
 rtl/ddr_pi_code_stepper.sv | 132 +++++++++++++
 tb/tb_ddr_pi_code_stepper.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ddr_pi_code_stepper.sv
// PI code/enable/gear sequencer: walks the code one LSB per step with a programmable dwell.
// `define DDR_PI_STEP_WRAP_EN for shortest-circular-path stepping; otherwise linear, non-wrapping.
module ddr_pi_code_stepper #(
  parameter int                CODE_W   = 6,
  parameter int                DWELL_W  = 8,
  parameter int                SETTLE_W = 8,
  parameter int                GEAR_W   = 4,
  parameter logic [CODE_W-1:0] RST_CODE = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [GEAR_W-1:0]   i_gear,
  input  logic [SETTLE_W-1:0] i_settle,
  input  logic [DWELL_W-1:0]  i_dwell,
  input  logic                i_req,
  input  logic [CODE_W-1:0]   i_tgt_code,
  output logic                o_ack,
  output logic                o_done,
  output logic                o_busy,
  output logic                o_ready,
  output logic                o_pi_en,
  output logic [GEAR_W-1:0]   o_pi_gear,
  output logic [CODE_W-1:0]   o_pi_code
);

  localparam int CNT_W = (SETTLE_W > DWELL_W) ? SETTLE_W : DWELL_W;

  typedef enum logic [2:0] {OFF, SETTLE, IDLE, STEP, DWELL} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CODE_W-1:0]  tgt;
  logic               step_up;
  logic [CODE_W-1:0]  next_code;

`ifdef DDR_PI_STEP_WRAP_EN
  logic [CODE_W-1:0]  diff;

  // Half-way distance (MSB set, rest zero) resolves upward.
  always_comb begin
    diff      = tgt - o_pi_code;
    step_up   = ~diff[CODE_W-1] | (diff[CODE_W-2:0] == '0);
    next_code = step_up ? o_pi_code + CODE_W'(1) : o_pi_code - CODE_W'(1);
  end
`else
  always_comb begin
    step_up   = tgt > o_pi_code;
    next_code = step_up ? o_pi_code + CODE_W'(1) : o_pi_code - CODE_W'(1);
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= OFF;
      cnt       <= '0;
      tgt       <= RST_CODE;
      o_ack     <= 1'b0;
      o_done    <= 1'b0;
      o_busy    <= 1'b0;
      o_ready   <= 1'b0;
      o_pi_en   <= 1'b0;
      o_pi_gear <= '0;
      o_pi_code <= RST_CODE;
    end else begin
      o_ack  <= 1'b0;
      o_done <= 1'b0;
      // Disable aborts any move and drops pending requests; the code is held.
      if (!i_en && state != OFF) begin
        state   <= OFF;
        cnt     <= '0;
        o_busy  <= 1'b0;
        o_ready <= 1'b0;
        o_pi_en <= 1'b0;
      end else begin
        case (state)
          OFF: begin
            o_pi_gear <= i_gear;
            if (i_en) begin
              state   <= SETTLE;
              cnt     <= CNT_W'(i_settle);
              o_pi_en <= 1'b1;
            end
          end
          SETTLE: begin
            if (cnt == '0) begin
              state   <= IDLE;
              o_ready <= 1'b1;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          IDLE: begin
            if (i_req) begin
              state   <= STEP;
              tgt     <= i_tgt_code;
              o_ack   <= 1'b1;
              o_busy  <= 1'b1;
              o_ready <= 1'b0;
            end
          end
          STEP: begin
            if (o_pi_code == tgt) begin
              state   <= IDLE;
              o_done  <= 1'b1;
              o_busy  <= 1'b0;
              o_ready <= 1'b1;
            end else begin
              o_pi_code <= next_code;
              if (next_code == tgt) begin
                state   <= IDLE;
                o_done  <= 1'b1;
                o_busy  <= 1'b0;
                o_ready <= 1'b1;
              end else if (i_dwell != '0) begin
                state <= DWELL;
                cnt   <= CNT_W'(i_dwell);
              end
            end
          end
          DWELL: begin
            // Loaded with D, so STEP resumes after exactly D idle cycles.
            cnt <= cnt - CNT_W'(1);
            if (cnt <= CNT_W'(1)) state <= STEP;
          end
          default: state <= OFF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_pi_code_stepper.sv
// Bench for ddr_pi_code_stepper: move table plus hand-written enable/abort/priority sequences.
module tb_ddr_pi_code_stepper;

  logic       clk = 1'b0;
  logic       rst, en, req;
  logic [3:0] gear;
  logic [7:0] settle, dwell;
  logic [5:0] tgt;
  logic       ack, done, busy, ready, pi_en;
  logic [3:0] pi_gear;
  logic [5:0] pi_code;

  ddr_pi_code_stepper dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_gear(gear), .i_settle(settle),
    .i_dwell(dwell), .i_req(req), .i_tgt_code(tgt), .o_ack(ack), .o_done(done),
    .o_busy(busy), .o_ready(ready), .o_pi_en(pi_en), .o_pi_gear(pi_gear),
    .o_pi_code(pi_code)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ack;
    logic       done;
    logic       busy;
    logic       ready;
    logic       pi_en;
    logic [3:0] gear;
    logic [5:0] code;
  } exp_t;

  typedef struct {
    logic [5:0] tgt;
    logic [7:0] dwell;
    int         k;
    bit         up;
  } mv_t;

  exp_t       sb[$];
  logic [3:0] eg;
  logic [5:0] cur;
  int         checks = 0;
  int         errors = 0;
  mv_t        mv[8];

  // Push the expectation for the coming edge, then compare after it.
  task automatic step(input string nm, input logic a, input logic d, input logic b,
                      input logic r, input logic p, input logic [5:0] c);
    exp_t e, got;
    sb.push_back({a, d, b, r, p, eg, c});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    got = {ack, done, busy, ready, pi_en, pi_gear, pi_code};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s: got ack=%b done=%b busy=%b ready=%b en=%b gear=%0d code=%0d, expected ack=%b done=%b busy=%b ready=%b en=%b gear=%0d code=%0d",
               nm, got.ack, got.done, got.busy, got.ready, got.pi_en, got.gear, got.code,
               e.ack, e.done, e.busy, e.ready, e.pi_en, e.gear, e.code);
    end
  endtask

  // Code changes after E1 + j*(D+1); done/busy=0 land with the final change.
  task automatic do_move(input string nm, input logic [5:0] start, input logic [5:0] t,
                         input logic [7:0] d, input int k, input bit up);
    int n, s;
    logic [5:0] c;
    req = 1'b1; tgt = t; dwell = d;
    step({nm, " ack"}, 1, 0, 1, 0, 1, start);
    req = 1'b0;
    if (k == 0) begin
      step({nm, " zero"}, 0, 1, 0, 1, 1, start);
    end else begin
      n = (k - 1) * (int'(d) + 1) + 1;
      for (int i = 1; i <= n; i++) begin
        s = (i - 1) / (int'(d) + 1) + 1;
        c = up ? start + 6'(s) : start - 6'(s);
        step(nm, 0, i == n, i != n, i == n, 1, c);
      end
    end
  endtask

  initial begin
    mv[0] = '{6'd4,  8'd0, 4, 1'b1};
    mv[1] = '{6'd2,  8'd2, 2, 1'b0};
`ifdef DDR_PI_STEP_WRAP_EN
    mv[2] = '{6'd62, 8'd0, 4, 1'b0};
    mv[3] = '{6'd1,  8'd0, 3, 1'b1};
    mv[6] = '{6'd1,  8'd0, 32, 1'b1};
`else
    mv[2] = '{6'd62, 8'd0, 60, 1'b1};
    mv[3] = '{6'd1,  8'd0, 61, 1'b0};
    mv[6] = '{6'd1,  8'd0, 32, 1'b0};
`endif
    mv[4] = '{6'd1,  8'd1, 0, 1'b1};
    mv[5] = '{6'd33, 8'd0, 32, 1'b1};
    mv[7] = '{6'd10, 8'd0, 9, 1'b1};

    rst = 1'b1; en = 1'b0; req = 1'b0; gear = 4'd5; settle = 8'd3; dwell = 8'd0; tgt = 6'd0;
    eg = 4'd0;
    step("reset0", 0, 0, 0, 0, 0, 6'd0);
    step("reset1", 0, 0, 0, 0, 0, 6'd0);
    rst = 1'b0;
    eg  = 4'd5;
    step("off gear", 0, 0, 0, 0, 0, 6'd0);

    en = 1'b1;
    for (int i = 0; i < 4; i++) step("settle", 0, 0, 0, 0, 1, 6'd0);
    step("ready", 0, 0, 0, 1, 1, 6'd0);
    gear = 4'd9;
    step("gear hold", 0, 0, 0, 1, 1, 6'd0);

    cur = 6'd0;
    for (int m = 0; m < 8; m++) begin
      do_move($sformatf("move%0d", m), cur, mv[m].tgt, mv[m].dwell, mv[m].k, mv[m].up);
      cur = mv[m].tgt;
    end

    // Abort: move 10->30, re-request while busy, disable at code 15.
    req = 1'b1; tgt = 6'd30; dwell = 8'd0;
    step("abort ack", 1, 0, 1, 0, 1, 6'd10);
    req = 1'b0;
    step("abort s1", 0, 0, 1, 0, 1, 6'd11);
    req = 1'b1; tgt = 6'd0;
    for (int i = 12; i <= 15; i++) step("busy req ignored", 0, 0, 1, 0, 1, 6'(i));
    en = 1'b0;
    step("abort off", 0, 0, 0, 0, 0, 6'd15);
    gear = 4'd7; eg = 4'd7;
    step("off hold", 0, 0, 0, 0, 0, 6'd15);
    req = 1'b0; en = 1'b1; settle = 8'd0;
    step("reenable", 0, 0, 0, 0, 1, 6'd15);
    step("reen ready", 0, 0, 0, 1, 1, 6'd15);
    do_move("same code", 6'd15, 6'd15, 8'd0, 0, 1'b1);

    // Disable wins over a simultaneous IDLE request.
    req = 1'b1; tgt = 6'd20; en = 1'b0;
    step("prio", 0, 0, 0, 0, 0, 6'd15);
    req = 1'b0;
    step("prio off", 0, 0, 0, 0, 0, 6'd15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
